// File: rtl/button_pkg.sv
// button_pkg: shared mode encodings and button channel indices for the button front end
package button_pkg;
  localparam logic [1:0] MODE_CLOCK     = 2'd0;
  localparam logic [1:0] MODE_SET_TIME  = 2'd1;
  localparam logic [1:0] MODE_SET_ALARM = 2'd2;
  localparam logic [1:0] MODE_SET_DATE  = 2'd3;
  localparam int NUM_BTN   = 4;
  localparam int BTN_UNITS = 0;
  localparam int BTN_TENS  = 1;
  localparam int BTN_3     = 2;
  localparam int BTN_AMPM  = 3;
endpackage

// File: rtl/button_ctrl_debounce_ch.sv
// debounce_ch: 2-flop synchroniser, debounce counter and rising-edge detector for one button
module debounce_ch #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic mclk,
  input  logic rst,
  input  logic raw,
  output logic rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES);
  logic sync1_q, sync2_q, stb_q, stb_d, stb_prev_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic hit;
  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    hit = (sync2_q != stb_q) && (cnt_inc == LIMIT);
    stb_d = hit ? ~stb_q : stb_q;
    cnt_d = (sync2_q != stb_q && !hit) ? cnt_inc : '0;
  end
  always_ff @(posedge mclk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stb_q      <= 1'b0;
      stb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      stb_q      <= stb_d;
      stb_prev_q <= stb_q;
      cnt_q      <= cnt_d;
    end
  end
  assign rise = stb_q & ~stb_prev_q;
endmodule

// File: rtl/button_ctrl.sv
// button_ctrl: debounced one-cycle button pulses, clk_mode register and inactivity timeout
module button_ctrl
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 20
) (
  input  logic               mclk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] pButton,
  input  logic               pMode,
  output logic [NUM_BTN-1:0] vButton,
  output logic [1:0]         clk_mode
);
  localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);
  logic [NUM_BTN:0] raw, rise;
  logic [NUM_BTN-1:0] vbutton_q, vbutton_d;
  logic [1:0] mode_q, mode_d;
  logic [31:0] idle_q, idle_d;
  assign raw = {pMode, pButton};
  for (genvar i = 0; i <= NUM_BTN; i++) begin : g_ch
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .mclk(mclk),
      .rst (rst),
      .raw (raw[i]),
      .rise(rise[i])
    );
  end
  // a mode press outranks the timeout that would land on the same edge
  always_comb begin
    vbutton_d = rise[NUM_BTN-1:0];
    mode_d = mode_q;
    idle_d = idle_q + 32'd1;
    if (rise[NUM_BTN]) begin
      mode_d = mode_q + 2'd1;
      idle_d = '0;
    end else if (mode_q == MODE_CLOCK || vbutton_q != '0) begin
      idle_d = '0;
    end else if (TIMEOUT_CYCLES != 0 && idle_q == IDLE_LAST) begin
      mode_d = MODE_CLOCK;
      idle_d = '0;
    end
  end
  always_ff @(posedge mclk) begin
    if (rst) begin
      vbutton_q <= '0;
      mode_q    <= MODE_CLOCK;
      idle_q    <= '0;
    end else begin
      vbutton_q <= vbutton_d;
      mode_q    <= mode_d;
      idle_q    <= idle_d;
    end
  end
  assign vButton  = vbutton_q;
  assign clk_mode = mode_q;
endmodule
